apple_iie_timing_generator: RTL

- Derives all CPU/RAM bus timing strobes from the 14.318 MHz master clock.
- Outputs clk_phi_0, clk_q3 and pras_n feed the memory management unit directly. The remaining strobes go to the RAM address mux, the video path and the CPU.
- Reproduces the Apple IIe cycle structure: 65 CPU cycles per scanline. Each cycle is 14 master ticks, except the last cycle of each line, which is stretched so the colour reference stays phase-locked.

---
 rtl/apple_iie_timing_pkg.sv | 53 +++++
 rtl/apple_iie_timing_generator.sv | 111 +++++++++++
 2 files changed

// File: rtl/apple_iie_timing_pkg.sv
// Shared timing constants for the Apple IIe bus timing generator.
// The MMU and video blocks import these so every block agrees on where the
// RAS/CAS/AX/Q3 edges fall inside a CPU cycle.
//   phase_t      : per-tick strobe vector (phi0, q3, pras_n, ax, pcas_n)
//   phase_decode : tick index + cycle length -> strobe vector
package apple_iie_timing_pkg;

    localparam int unsigned DEF_CYCLES_PER_LINE = 65;
    localparam int unsigned DEF_SHORT_TICKS     = 14;
    localparam int unsigned DEF_LONG_EXTRA      = 2;

    // Tick offsets within each half cycle (phi1 half, then phi0 half)
    localparam int unsigned RAS_OFFSET    = 3;
    localparam int unsigned AX_OFFSET     = 4;
    localparam int unsigned CAS_OFFSET    = 5;
    localparam int unsigned Q3_LOW_OFFSET = 4;

    typedef enum logic {
        ST_HOLD,
        ST_RUN
    } run_state_t;

    typedef struct packed {
        logic phi_0;
        logic q3;
        logic pras_n;
        logic ax;
        logic pcas_n;
    } phase_t;

    // A strobe is low from its offset to the end of each half cycle. The
    // phi0 half runs to len-1, so stretching the cycle stretches its low time.
    function automatic phase_t phase_decode(input logic [3:0]  t,
                                            input logic [4:0]  len,
                                            input int unsigned half);
        int unsigned ti;
        int unsigned li;
        phase_t      p;
        ti = 32'(t);
        li = 32'(len);
        p.phi_0  = (ti >= half);
        p.q3     = !((ti >= Q3_LOW_OFFSET && ti < half) ||
                     (ti >= half + Q3_LOW_OFFSET && ti < li));
        p.pras_n = !((ti >= RAS_OFFSET && ti < half) ||
                     (ti >= half + RAS_OFFSET && ti < li));
        p.ax     = !((ti >= AX_OFFSET && ti < half) ||
                     (ti >= half + AX_OFFSET && ti < li));
        p.pcas_n = !((ti >= CAS_OFFSET && ti < half) ||
                     (ti >= half + CAS_OFFSET && ti < li));
        return p;
    endfunction

endpackage

// File: rtl/apple_iie_timing_generator.sv
// Apple IIe CPU/RAM bus timing generator.
// Divides the 14.318 MHz master clock into 65 CPU cycles per scanline; the
// last cycle of each line is stretched by LONG_EXTRA ticks (phi0 high) so the
// colour reference stays phase-locked to the line.
// Ports:
//   clk_14m        master clock
//   reset          synchronous, active-high
//   clk_7m         master/2
//   clk_color_ref  master/4, free running
//   clk_phi_0/1    CPU phases (phi0 high = CPU bus phase)
//   clk_q3         asymmetric 2 MHz strobe
//   pras_n/pcas_n  RAM row/column strobes, active low
//   ax             RAM address mux select, 1 = row address
//   line_start     one-tick pulse at tick 0 of cycle 0
//   long_cycle     high during the stretched cycle
//   cycle_count    CPU cycle index within the line
module apple_iie_timing_generator
    import apple_iie_timing_pkg::*;
#(
    parameter int unsigned CYCLES_PER_LINE = DEF_CYCLES_PER_LINE,
    parameter int unsigned SHORT_TICKS     = DEF_SHORT_TICKS,
    parameter int unsigned LONG_EXTRA      = DEF_LONG_EXTRA
) (
    input  logic       clk_14m,
    input  logic       reset,
    output logic       clk_7m,
    output logic       clk_color_ref,
    output logic       clk_phi_0,
    output logic       clk_phi_1,
    output logic       clk_q3,
    output logic       pras_n,
    output logic       pcas_n,
    output logic       ax,
    output logic       line_start,
    output logic       long_cycle,
    output logic [6:0] cycle_count
);

    localparam int unsigned HALF       = SHORT_TICKS / 2;
    localparam logic [4:0]  SHORT_LEN  = 5'(SHORT_TICKS);
    localparam logic [4:0]  LONG_LEN   = 5'(SHORT_TICKS + LONG_EXTRA);
    localparam logic [6:0]  LAST_CYCLE = 7'(CYCLES_PER_LINE - 1);

    run_state_t state_q;
    logic [3:0] t_q, t_d;
    logic [6:0] cyc_q, cyc_d;
    logic [1:0] c_q, c_d;
    logic [4:0] len_q, len_d;
    phase_t     ph_d;

    // Next-state counters. The first edge after reset release lands on
    // t=0 of cycle 0 (rather than t=1), hence the ST_HOLD step.
    always_comb begin
        len_q = (cyc_q == LAST_CYCLE) ? LONG_LEN : SHORT_LEN;
        t_d   = t_q;
        cyc_d = cyc_q;
        c_d   = c_q;
        if (state_q == ST_HOLD) begin
            t_d   = '0;
            cyc_d = '0;
            c_d   = '0;
        end else begin
            c_d = c_q + 2'd1;
            if ({1'b0, t_q} == len_q - 5'd1) begin
                t_d   = '0;
                cyc_d = (cyc_q == LAST_CYCLE) ? '0 : cyc_q + 7'd1;
            end else begin
                t_d = t_q + 4'd1;
            end
        end
        len_d = (cyc_d == LAST_CYCLE) ? LONG_LEN : SHORT_LEN;
        ph_d  = phase_decode(t_d, len_d, HALF);
    end

    always_ff @(posedge clk_14m) begin
        if (reset) begin
            state_q       <= ST_HOLD;
            t_q           <= '0;
            cyc_q         <= '0;
            c_q           <= '0;
            clk_7m        <= 1'b0;
            clk_color_ref <= 1'b0;
            clk_phi_0     <= 1'b0;
            clk_phi_1     <= 1'b1;
            clk_q3        <= 1'b1;
            pras_n        <= 1'b1;
            pcas_n        <= 1'b1;
            ax            <= 1'b1;
            line_start    <= 1'b0;
            long_cycle    <= 1'b0;
        end else begin
            state_q       <= ST_RUN;
            t_q           <= t_d;
            cyc_q         <= cyc_d;
            c_q           <= c_d;
            clk_7m        <= c_d[0];
            clk_color_ref <= c_d[1];
            clk_phi_0     <= ph_d.phi_0;
            clk_phi_1     <= ~ph_d.phi_0;
            clk_q3        <= ph_d.q3;
            pras_n        <= ph_d.pras_n;
            pcas_n        <= ph_d.pcas_n;
            ax            <= ph_d.ax;
            line_start    <= (t_d == 4'd0) && (cyc_d == 7'd0);
            long_cycle    <= (cyc_d == LAST_CYCLE);
        end
    end

    assign cycle_count = cyc_q;

endmodule
